axi_sram_slave: RTL and testbench



---
 rtl/axi_sram_slave.sv | 227 ++++++++++++++++++++++
 tb/tb_axi_sram_slave.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI4 subordinate backed by a 64-bit SRAM array with independent read/write FSMs
//   clk      : clock
//   rstn     : synchronous active-low reset
//   axi_i    : AW/W/AR channels plus b_ready/r_ready from the manager
//   axi_o    : aw_ready/w_ready/ar_ready plus B and R channels
//   wr_beats : accepted W beats since reset (wraps)
//   rd_beats : completed R beats since reset (wraps)
package axi_sram_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam int ID_W = 4;
  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [ADDR_W-1:0] addr;
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
  } axi_ax_t;
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [DATA_W/8-1:0] strb;
    logic last;
  } axi_w_t;
  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [1:0] resp;
  } axi_b_t;
  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [DATA_W-1:0] data;
    logic [1:0] resp;
    logic last;
  } axi_r_t;
  typedef struct packed {
    axi_ax_t aw;
    logic aw_valid;
    axi_w_t w;
    logic w_valid;
    logic b_ready;
    axi_ax_t ar;
    logic ar_valid;
    logic r_ready;
  } axi_req_t;
  typedef struct packed {
    logic aw_ready;
    logic w_ready;
    axi_b_t b;
    logic b_valid;
    logic ar_ready;
    axi_r_t r;
    logic r_valid;
  } axi_resp_t;
endpackage

module axi_sram_slave import axi_sram_pkg::*; #(
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 64,
  parameter int AXI_ID_W = 4,
  parameter int DEPTH_WORDS = 1024,
  parameter logic [AXI_ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic        clk,
  input  logic        rstn,
  input  axi_req_t    axi_i,
  output axi_resp_t   axi_o,
  output logic [31:0] wr_beats,
  output logic [31:0] rd_beats
);
  localparam int IW = $clog2(DEPTH_WORDS);
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;
  logic [AXI_DATA_W-1:0] r_mem [DEPTH_WORDS];
  // The extra MSB catches addresses below BASE_ADDR as a borrow.
  function automatic logic f_in_range(input logic [AXI_ADDR_W-1:0] a);
    logic [AXI_ADDR_W:0] o;
    o = {1'b0, a} - {1'b0, BASE_ADDR};
    return !o[AXI_ADDR_W] && ((o >> 3) < (AXI_ADDR_W+1)'(DEPTH_WORDS));
  endfunction
  function automatic logic [IW-1:0] f_idx(input logic [AXI_ADDR_W-1:0] a);
    logic [AXI_ADDR_W-1:0] o;
    o = a - BASE_ADDR;
    return IW'(o >> 3);
  endfunction
  function automatic logic [AXI_ADDR_W-1:0] f_next(input logic [AXI_ADDR_W-1:0] a, input logic [1:0] b);
    return b == 2'b01 ? a + AXI_ADDR_W'(8) : a;
  endfunction
  // WRAP, reserved bursts and any size other than 8 bytes are refused outright.
  function automatic logic f_err(input logic [1:0] b, input logic [2:0] s);
    return b[1] || s != 3'd3;
  endfunction
  w_state_e r_ws, w_ws_nx;
  logic r_aw_ready, r_w_ready, r_b_valid, r_werr;
  logic [AXI_ID_W-1:0] r_bid;
  logic [1:0] r_bresp, r_wburst;
  logic [AXI_ADDR_W-1:0] r_waddr;
  logic [7:0] r_wlen, r_wcnt;
  logic w_aw_hs, w_w_hs, w_b_hs, w_wend, w_winr;
  assign w_aw_hs = axi_i.aw_valid && r_aw_ready;
  assign w_w_hs = axi_i.w_valid && r_w_ready;
  assign w_b_hs = r_b_valid && axi_i.b_ready;
  assign w_wend = r_wcnt == r_wlen;
  assign w_winr = f_in_range(r_waddr);
  always_comb begin
    w_ws_nx = (r_ws == W_IDLE && w_aw_hs) ? W_DATA :
              (r_ws == W_DATA && w_w_hs && w_wend) ? W_RESP :
              (r_ws == W_RESP && w_b_hs) ? W_IDLE : r_ws;
  end
  // Readies and valids are registered from the next state so they are all low through reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_ws <= W_IDLE;
      r_aw_ready <= 1'b0;
      r_w_ready <= 1'b0;
      r_b_valid <= 1'b0;
    end else begin
      r_ws <= w_ws_nx;
      r_aw_ready <= w_ws_nx == W_IDLE;
      r_w_ready <= w_ws_nx == W_DATA;
      r_b_valid <= w_ws_nx == W_RESP;
    end
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_bid <= '0;
      r_bresp <= 2'b00;
      r_waddr <= '0;
      r_wlen <= '0;
      r_wcnt <= '0;
      r_wburst <= 2'b00;
      r_werr <= 1'b0;
      wr_beats <= '0;
    end else begin
      if (w_aw_hs) begin
        r_bid <= axi_i.aw.id;
        r_waddr <= axi_i.aw.addr;
        r_wlen <= axi_i.aw.len;
        r_wcnt <= '0;
        r_wburst <= axi_i.aw.burst;
        r_werr <= f_err(axi_i.aw.burst, axi_i.aw.size);
        r_bresp <= f_err(axi_i.aw.burst, axi_i.aw.size) ? 2'b10 : 2'b00;
      end
      if (w_w_hs) begin
        wr_beats <= wr_beats + 32'd1;
        r_wcnt <= r_wcnt + 8'd1;
        r_waddr <= f_next(r_waddr, r_wburst);
        r_bresp <= (r_bresp == 2'b10 || axi_i.w.last != w_wend) ? 2'b10 : !w_winr ? 2'b11 : r_bresp;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rstn && w_w_hs && w_winr && !r_werr)
      for (int i = 0; i < AXI_DATA_W/8; i++)
        if (axi_i.w.strb[i]) r_mem[f_idx(r_waddr)][i*8 +: 8] <= axi_i.w.data[i*8 +: 8];
  end
  r_state_e r_rs, w_rs_nx;
  logic r_ar_ready, r_rvalid, r_rlast, r_rerr;
  logic [1:0] r_rresp, r_rburst;
  logic [AXI_DATA_W-1:0] r_rdata;
  logic [AXI_ID_W-1:0] r_rid;
  logic [AXI_ADDR_W-1:0] r_raddr;
  logic [7:0] r_rlen, r_rcnt;
  logic w_ar_hs, w_r_hs, w_fetch, w_ferr, w_finr, w_flast;
  logic [AXI_ADDR_W-1:0] w_fa;
  logic [1:0] w_fburst;
  assign w_ar_hs = axi_i.ar_valid && r_ar_ready;
  assign w_r_hs = r_rvalid && axi_i.r_ready;
  // A fetch happens on AR acceptance and on every non-final R handshake, so beats stream without gaps.
  assign w_fetch = w_ar_hs || (w_r_hs && !r_rlast);
  assign w_fa = w_ar_hs ? axi_i.ar.addr : r_raddr;
  assign w_fburst = w_ar_hs ? axi_i.ar.burst : r_rburst;
  assign w_ferr = w_ar_hs ? f_err(axi_i.ar.burst, axi_i.ar.size) : r_rerr;
  assign w_finr = f_in_range(w_fa);
  assign w_flast = w_ar_hs ? axi_i.ar.len == 8'd0 : r_rcnt + 8'd1 == r_rlen;
  always_comb begin
    w_rs_nx = (r_rs == R_IDLE && w_ar_hs) ? R_DATA :
              (r_rs == R_DATA && w_r_hs && r_rlast) ? R_IDLE : r_rs;
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_rs <= R_IDLE;
      r_ar_ready <= 1'b0;
      r_rvalid <= 1'b0;
      r_rlast <= 1'b0;
      r_rerr <= 1'b0;
      r_rresp <= 2'b00;
      r_rburst <= 2'b00;
      r_rdata <= '0;
      r_rid <= '0;
      r_raddr <= '0;
      r_rlen <= '0;
      r_rcnt <= '0;
      rd_beats <= '0;
    end else begin
      r_rs <= w_rs_nx;
      r_ar_ready <= w_rs_nx == R_IDLE;
      if (w_ar_hs) begin
        r_rid <= axi_i.ar.id;
        r_rlen <= axi_i.ar.len;
        r_rburst <= axi_i.ar.burst;
        r_rerr <= f_err(axi_i.ar.burst, axi_i.ar.size);
        r_rcnt <= '0;
      end else if (w_r_hs) r_rcnt <= r_rcnt + 8'd1;
      if (w_fetch) begin
        r_rvalid <= 1'b1;
        r_rdata <= (w_ferr || !w_finr) ? '0 : r_mem[f_idx(w_fa)];
        r_rresp <= w_ferr ? 2'b10 : !w_finr ? 2'b11 : 2'b00;
        r_rlast <= w_flast;
        r_raddr <= f_next(w_fa, w_fburst);
      end else if (w_r_hs) r_rvalid <= 1'b0;
      if (w_r_hs) rd_beats <= rd_beats + 32'd1;
    end
  end
  always_comb begin
    axi_o = '0;
    axi_o.aw_ready = r_aw_ready;
    axi_o.w_ready = r_w_ready;
    axi_o.b_valid = r_b_valid;
    axi_o.b.id = r_bid;
    axi_o.b.resp = r_bresp;
    axi_o.ar_ready = r_ar_ready;
    axi_o.r_valid = r_rvalid;
    axi_o.r.id = r_rid;
    axi_o.r.data = r_rdata;
    axi_o.r.resp = r_rresp;
    axi_o.r.last = r_rlast;
  end
endmodule

// File: tb/tb_axi_sram_slave.sv
// tb_axi_sram_slave: scoreboard bench for axi_sram_slave
module tb_axi_sram_slave;
  import axi_sram_pkg::*;
  localparam int DEPTH = 1024;
  typedef struct {logic [63:0] d; logic [1:0] resp; logic last; logic [3:0] id;} rexp_t;
  typedef struct {logic [3:0] id; logic [1:0] resp;} bexp_t;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  axi_req_t req;
  axi_resp_t rsp;
  logic [31:0] wr_beats, rd_beats;
  int pass_n = 0, total_n = 0, exp_wr = 0, exp_rd = 0;
  logic [63:0] mm [DEPTH];
  rexp_t rq[$];
  bexp_t bq[$];
  always #5 clk = ~clk;
  axi_sram_slave #(.DEPTH_WORDS(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .axi_i(req), .axi_o(rsp), .wr_beats(wr_beats), .rd_beats(rd_beats)
  );
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total_n++;
    if (got === exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  function automatic logic rdy(input int ch);
    return ch == 0 ? rsp.aw_ready : ch == 1 ? rsp.w_ready : ch == 2 ? rsp.b_valid : rsp.ar_ready;
  endfunction
  function automatic bit inr(input logic [31:0] a);
    return (a >> 3) < 32'(DEPTH);
  endfunction
  task automatic hs_wait(input int ch);
    int n = 0;
    @(negedge clk);
    while (!rdy(ch) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("hs_ch%0d", ch), 128'(rdy(ch)), 128'(1));
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                    input logic [1:0] burst, input logic [2:0] size, input logic [63:0] d0,
                    input logic [7:0] strb);
    bexp_t b, g;
    logic [31:0] a = addr;
    logic [63:0] d;
    bit err = burst == 2'b10 || size != 3'd3;
    b.id = id;
    b.resp = err ? 2'b10 : 2'b00;
    for (int k = 0; k <= int'(len); k++) begin
      d = d0 + 64'(k);
      if (!inr(a)) begin
        if (b.resp != 2'b10) b.resp = 2'b11;
      end else if (!err)
        for (int i = 0; i < 8; i++) if (strb[i]) mm[a[12:3]][i*8 +: 8] = d[i*8 +: 8];
      if (burst == 2'b01) a += 32'd8;
    end
    bq.push_back(b);
    req.aw = '{id: id, addr: addr, len: len, size: size, burst: burst};
    req.aw_valid = 1'b1;
    hs_wait(0);
    req.aw_valid = 1'b0;
    @(negedge clk);
    check("aw_drop", 128'(rsp.aw_ready), 128'(0));
    @(posedge clk);
    #1;
    for (int k = 0; k <= int'(len); k++) begin
      req.w = '{data: d0 + 64'(k), strb: strb, last: k == int'(len)};
      req.w_valid = 1'b1;
      hs_wait(1);
      exp_wr++;
    end
    req.w_valid = 1'b0;
    hs_wait(2);
    g = bq.pop_front();
    check("b_id", 128'(rsp.b.id), 128'(g.id));
    check("b_resp", 128'(rsp.b.resp), 128'(g.resp));
    req.b_ready = 1'b1;
    @(negedge clk);
    check("b_hold", 128'(rsp.b_valid), 128'(1));
    @(posedge clk);
    #1;
    req.b_ready = 1'b0;
    @(negedge clk);
    check("aw_back", 128'(rsp.aw_ready), 128'(1));
    check("wr_beats", 128'(wr_beats), 128'(exp_wr));
    @(posedge clk);
    #1;
  endtask
  task automatic rd(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                    input logic [1:0] burst, input logic [2:0] size, input bit toggle);
    rexp_t e;
    logic [31:0] a = addr;
    logic [63:0] held = '0;
    bit err = burst == 2'b10 || size != 3'd3;
    bit stalled = 1'b0;
    int cyc = 0;
    for (int k = 0; k <= int'(len); k++) begin
      e.d = (err || !inr(a)) ? 64'd0 : mm[a[12:3]];
      e.resp = err ? 2'b10 : !inr(a) ? 2'b11 : 2'b00;
      e.last = k == int'(len);
      e.id = id;
      rq.push_back(e);
      if (burst == 2'b01) a += 32'd8;
    end
    req.ar = '{id: id, addr: addr, len: len, size: size, burst: burst};
    req.ar_valid = 1'b1;
    hs_wait(3);
    req.ar_valid = 1'b0;
    while (rq.size() > 0 && cyc < 2000) begin
      req.r_ready = toggle ? !cyc[0] : 1'b1;
      @(negedge clk);
      if (rsp.r_valid) begin
        if (stalled) check("r_stable", 128'(rsp.r.data), 128'(held));
        if (req.r_ready) begin
          e = rq.pop_front();
          check("r_data", 128'(rsp.r.data), 128'(e.d));
          check("r_resp", 128'(rsp.r.resp), 128'(e.resp));
          check("r_last", 128'(rsp.r.last), 128'(e.last));
          check("r_id", 128'(rsp.r.id), 128'(e.id));
          exp_rd++;
          stalled = 1'b0;
        end else begin
          held = rsp.r.data;
          stalled = 1'b1;
        end
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    req.r_ready = 1'b0;
    check("r_pending", 128'(rq.size()), 128'(0));
    @(negedge clk);
    check("r_idle", 128'(rsp.r_valid), 128'(0));
    check("rd_beats", 128'(rd_beats), 128'(exp_rd));
    @(posedge clk);
    #1;
  endtask
  initial begin
    req = '0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_axi_o", 128'(rsp), 128'(0));
    check("rst_wr", 128'(wr_beats), 128'(0));
    check("rst_rd", 128'(rd_beats), 128'(0));
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(negedge clk);
    check("aw_rdy_hold", 128'(rsp.aw_ready), 128'(0));
    @(negedge clk);
    check("aw_rdy_rel", 128'(rsp.aw_ready), 128'(1));
    check("ar_rdy_rel", 128'(rsp.ar_ready), 128'(1));
    @(posedge clk);
    #1;
    wr(4'h3, 32'h40, 8'd2, 2'b01, 3'd3, 64'hA000_0000_0000_000A, 8'hFF);
    rd(4'h5, 32'h40, 8'd2, 2'b01, 3'd3, 1'b1);
    wr(4'h1, 32'h0, 8'd0, 2'b01, 3'd3, 64'h1122_3344_5566_7788, 8'hFF);
    wr(4'h2, 32'h0, 8'd0, 2'b01, 3'd3, 64'h1111_2222_3333_4444, 8'h0F);
    rd(4'h2, 32'h0, 8'd0, 2'b01, 3'd3, 1'b0);
    wr(4'h6, 32'((DEPTH - 1) * 8), 8'd3, 2'b01, 3'd3, 64'hBEEF_0000, 8'hFF);
    rd(4'h6, 32'((DEPTH - 1) * 8), 8'd3, 2'b01, 3'd3, 1'b1);
    rd(4'h7, 32'h0, 8'd0, 2'b01, 3'd3, 1'b0);
    wr(4'h8, 32'h40, 8'd3, 2'b10, 3'd3, 64'hDEAD, 8'hFF);
    rd(4'h8, 32'h40, 8'd2, 2'b01, 3'd3, 1'b0);
    rd(4'h9, 32'h40, 8'd3, 2'b10, 3'd3, 1'b0);
    wr(4'hA, 32'h48, 8'd1, 2'b01, 3'd2, 64'hCAFE, 8'hFF);
    rd(4'hB, 32'h48, 8'd1, 2'b01, 3'd2, 1'b0);
    rd(4'hB, 32'h48, 8'd0, 2'b01, 3'd3, 1'b0);
    wr(4'hC, 32'h100, 8'd2, 2'b00, 3'd3, 64'h77, 8'hFF);
    rd(4'hC, 32'h100, 8'd1, 2'b00, 3'd3, 1'b1);
    req.aw = '{id: 4'hD, addr: 32'h300, len: 8'd3, size: 3'd3, burst: 2'b01};
    req.aw_valid = 1'b1;
    hs_wait(0);
    req.aw_valid = 1'b0;
    req.w = '{data: 64'h5555, strb: 8'hFF, last: 1'b0};
    req.w_valid = 1'b1;
    hs_wait(1);
    req.w.data = 64'h6666;
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    req.w_valid = 1'b0;
    @(negedge clk);
    check("rst_b_valid", 128'(rsp.b_valid), 128'(0));
    check("rst_w_ready", 128'(rsp.w_ready), 128'(0));
    check("rst_wr2", 128'(wr_beats), 128'(0));
    check("rst_rd2", 128'(rd_beats), 128'(0));
    exp_wr = 0;
    exp_rd = 0;
    @(posedge clk);
    #1;
    wr(4'hE, 32'h200, 8'd1, 2'b01, 3'd3, 64'h9999_0000, 8'hFF);
    rd(4'hE, 32'h200, 8'd1, 2'b01, 3'd3, 1'b0);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
